// File: rtl/mema_ctrl_pkg.sv
// Shared definitions for the A/B array-feed controllers: FSM state encoding
// and the length of the systolic shift sequence.
package mema_ctrl_pkg;

   // Controller states, shared with the B-side controller.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      LOADED = 3'd2,
      SHIFT  = 3'd3,
      DONE   = 3'd4
   } mema_state_e;

   // A DIM x DIM matrix needs 2*DIM-1 shift cycles to drain diagonally
   // through the array.
   function automatic int unsigned shift_len(input int unsigned dim);
      return (2 * dim) - 1;
   endfunction

endpackage : mema_ctrl_pkg

// File: rtl/mema_ctrl.sv
// A-side matrix controller: accepts DIM rows over a valid/ready handshake,
// writes each into the A buffer one cycle later, then on start drives the
// shift enable for the full diagonal drain and pulses done.
module mema_ctrl
   import mema_ctrl_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        row_valid,
   input  logic signed [DIM-1:0][BITS_AB-1:0]          row_data,
   output logic                                        row_ready,
   input  logic                                        start,
   output logic                                        WrEn,
   output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0]    Arow,
   output logic signed [DIM-1:0][BITS_AB-1:0]          Ain,
   output logic                                        en,
   output logic                                        busy,
   output logic                                        done
);

   // Row index width; a single-row matrix still needs a 1-bit index port.
   localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
   // Row counter must reach DIM without wrapping.
   localparam int RCW = $clog2(DIM + 1);
   // Shift counter only needs to reach 2*DIM-2 (index of the last en cycle).
   localparam int SCW = $clog2(2 * DIM);

   localparam logic [RCW-1:0] ROW_LAST   = RCW'(DIM - 1);
   localparam logic [SCW-1:0] SHIFT_LAST = SCW'(shift_len(DIM) - 1);

   mema_state_e                        state_q, state_d;
   logic [RCW-1:0]                     row_cnt_q, row_cnt_d;
   logic [SCW-1:0]                     sh_cnt_q, sh_cnt_d;

   logic                               wren_q, wren_d;
   logic [AW-1:0]                      arow_q, arow_d;
   logic signed [DIM-1:0][BITS_AB-1:0] ain_q, ain_d;
   logic                               en_q, en_d;
   logic                               busy_q, busy_d;
   logic                               done_q, done_d;

   logic                               ready_st;
   logic                               xfer;

   // Ready is a pure state decode; it is additionally held low while reset
   // is asserted so upstream never sees ready during reset.
   assign ready_st  = (state_q == IDLE) || (state_q == LOAD);
   assign row_ready = ready_st && rst_n;
   assign xfer      = row_valid && ready_st;

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      sh_cnt_d  = sh_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               row_cnt_d = row_cnt_q + 1'b1;
               state_d   = (DIM == 1) ? LOADED : LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == ROW_LAST) begin
                  state_d = LOADED;
               end
            end
         end
         LOADED: begin
            if (start) begin
               state_d  = SHIFT;
               sh_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (sh_cnt_q == SHIFT_LAST) begin
               state_d = DONE;
            end else begin
               sh_cnt_d = sh_cnt_q + 1'b1;
            end
         end
         DONE: begin
            // Counters are cleared on the way back to IDLE.
            state_d   = IDLE;
            row_cnt_d = '0;
            sh_cnt_d  = '0;
         end
         default: begin
            state_d   = IDLE;
            row_cnt_d = '0;
            sh_cnt_d  = '0;
         end
      endcase

      // Write strobe follows the accepted transfer by one cycle; index and
      // data hold their last values between writes.
      wren_d = xfer;
      arow_d = xfer ? row_cnt_q[AW-1:0] : arow_q;
      ain_d  = xfer ? row_data : ain_q;

      // Status outputs are registered decodes of the upcoming state, so
      // they line up exactly with the state they describe.
      en_d   = (state_d == SHIFT);
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   // State, counters and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_cnt_q <= '0;
         sh_cnt_q  <= '0;
         wren_q    <= 1'b0;
         arow_q    <= '0;
         ain_q     <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         sh_cnt_q  <= sh_cnt_d;
         wren_q    <= wren_d;
         arow_q    <= arow_d;
         ain_q     <= ain_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign WrEn = wren_q;
   assign Arow = arow_q;
   assign Ain  = ain_q;
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : mema_ctrl

// File: tb/tb_mema_ctrl.sv
// Self-checking bench for mema_ctrl (DIM=8, BITS_AB=8): row writes are
// checked against a scoreboard queue; shift timing against fixed cycle maps.
module tb_mema_ctrl;

   localparam int BITS_AB = 8;
   localparam int DIM     = 8;
   localparam int AW      = 3;
   localparam int DW      = DIM * BITS_AB;

   typedef struct packed {
      logic [AW-1:0] row;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          row_valid;
   logic [DW-1:0] row_data;
   logic          row_ready;
   logic          start;
   logic          WrEn;
   logic [AW-1:0] Arow;
   logic [DW-1:0] Ain;
   logic          en;
   logic          busy;
   logic          done;

   wr_t           sb_q[$];
   wr_t           mon_e;
   int            n_cmp      = 0;
   int            n_bad      = 0;
   int            en_total   = 0;
   int            done_total = 0;
   logic [DW-1:0] last_row   = '0;

   always #5 clk = ~clk;

   mema_ctrl #(
      .BITS_AB(BITS_AB),
      .DIM    (DIM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .row_valid(row_valid),
      .row_data (row_data),
      .row_ready(row_ready),
      .start    (start),
      .WrEn     (WrEn),
      .Arow     (Arow),
      .Ain      (Ain),
      .en       (en),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("wr_en_excl", 64'(WrEn & en), 64'd0);
         if (WrEn) begin
            if (sb_q.size() == 0) begin
               chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("arow", 64'(Arow), 64'(mon_e.row));
               chk("ain", Ain, mon_e.data);
               $display("write row %0d data %h", Arow, Ain);
            end
         end
         if (en)   en_total++;
         if (done) done_total++;
      end
   end

   // Load DIM rows, optionally with an idle cycle before each, optionally
   // raising start together with the last transfer.
   task automatic load_rows(input bit gapped, input bit incr, input bit start_last);
      logic [DW-1:0] d;
      for (int i = 0; i < DIM; i++) begin
         if (gapped) begin
            row_valid = 1'b0;
            row_data  = {$urandom, $urandom};
            step();
         end
         d         = incr ? {DIM{8'(i + 1)}} : {$urandom, $urandom};
         row_valid = 1'b1;
         row_data  = d;
         start     = start_last && (i == DIM - 1);
         chk("rdy_load", 64'(row_ready), 64'd1);
         sb_q.push_back('{row: AW'(i), data: d});
         last_row  = d;
         step();
      end
      row_valid = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      chk("rdy_loaded", 64'(row_ready), 64'd0);
      chk("busy_loaded", 64'(busy), 64'd1);
      step();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
   endtask

   // Start a shift from LOADED and check the 17-cycle timeline; optionally
   // hold row_valid high with all-ones data throughout.
   task automatic run_shift(input bit blocked);
      int en0;
      int d0;
      en0       = en_total;
      d0        = done_total;
      start     = 1'b1;
      row_valid = blocked;
      row_data  = '1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         chk("en_seq", 64'(en), 64'(c <= 15));
         chk("done_seq", 64'(done), 64'(c == 16));
         chk("busy_seq", 64'(busy), 64'(c <= 16));
         chk("rdy_seq", 64'(row_ready), 64'(c == 17));
         if (blocked) chk("ain_hold", Ain, last_row);
         row_valid = blocked && (c < 16);
         step();
      end
      chk("en_count", 64'(en_total - en0), 64'd15);
      chk("done_count", 64'(done_total - d0), 64'd1);
   endtask

   // Start a shift, then assert reset after five en cycles.
   task automatic shift_reset();
      int d0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk("en_pre_rst", 64'(en), 64'd1);
      end
      #1 rst_n = 1'b0;
      #1;
      d0 = done_total;
      chk("rst_en", 64'(en), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wren", 64'(WrEn), 64'd0);
      chk("rst_arow", 64'(Arow), 64'd0);
      chk("rst_ain", Ain, 64'd0);
      chk("rst_rdy", 64'(row_ready), 64'd0);
      repeat (2) @(negedge clk);
      chk("rst_hold_en", 64'(en), 64'd0);
      #1 rst_n = 1'b1;
      #1;
      chk("rel_rdy", 64'(row_ready), 64'd1);
      chk("rel_busy", 64'(busy), 64'd0);
      step();
      chk("rst_no_done", 64'(done_total - d0), 64'd0);
   endtask

   initial begin
      int en0;
      rst_n     = 1'b0;
      row_valid = 1'b0;
      start     = 1'b0;
      row_data  = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("init_rdy", 64'(row_ready), 64'd0);
      chk("init_wren", 64'(WrEn), 64'd0);
      chk("init_en", 64'(en), 64'd0);
      chk("init_done", 64'(done), 64'd0);
      chk("init_busy", 64'(busy), 64'd0);
      chk("init_arow", 64'(Arow), 64'd0);
      chk("init_ain", Ain, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("init_rel_rdy", 64'(row_ready), 64'd1);
      step();

      // Start in IDLE is ignored.
      en0   = en_total;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("idle_start_busy", 64'(busy), 64'd0);
      chk("idle_start_en", 64'(en), 64'd0);
      step();

      // Back-to-back load 0x01..0x08 with start on the last transfer.
      load_rows(1'b0, 1'b1, 1'b1);
      repeat (3) step();
      chk("early_start_en", 64'(en_total - en0), 64'd0);
      chk("early_start_busy", 64'(busy), 64'd1);
      chk("early_start_rdy", 64'(row_ready), 64'd0);

      // Normal shift.
      run_shift(1'b0);

      // Gapped load, then shift with rows blocked.
      load_rows(1'b1, 1'b0, 1'b0);
      run_shift(1'b1);

      // Reset mid-shift, then a fresh load and shift.
      load_rows(1'b0, 1'b0, 1'b0);
      shift_reset();
      load_rows(1'b0, 1'b1, 1'b0);
      run_shift(1'b0);

      chk("sb_final", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mema_ctrl

// File: doc/mema_ctrl.md
MEMA_CTRL -- requirements
Module: mema_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- BITS_AB, 8, signed element width of A
- DIM, 8, array dimension: rows per matrix and elements per row
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- row_valid  input  1  upstream has an A row on row_data
- row_data  input  DIM x BITS_AB signed  one A row, element j in slot j
- row_ready  output  1  controller accepts a row this cycle
- start  input  1  request to shift the loaded matrix into the array
- WrEn  output  1  row write strobe to the A buffer
- Arow  output  $clog2(DIM)  row index for WrEn
- Ain  output  DIM x BITS_AB signed  row data for WrEn
- en  output  1  shift enable to the A buffer
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when the shift sequence completes

Function
REQ-003 State machine SHALL have states IDLE, LOAD, LOADED, SHIFT, DONE.
REQ-004 A row transfer SHALL occur on a cycle where row_valid and row_ready are both 1; row_data SHALL be ignored on any other cycle.
REQ-005 row_ready SHALL be 1 in IDLE and LOAD, 0 in LOADED, SHIFT and DONE.
REQ-006 A transfer in cycle N SHALL produce WrEn=1, Arow=k, Ain=row_data(N) in cycle N+1, where k is the count of earlier transfers in the current matrix (0..DIM-1).
REQ-007 WrEn SHALL be 0 in every cycle not covered by REQ-006; Ain and Arow SHALL hold their last values when WrEn=0.
REQ-008 First transfer SHALL move IDLE->LOAD; the DIM-th transfer SHALL move to LOADED on the next cycle; gaps in row_valid SHALL stall the load without other effect.
REQ-009 For DIM=1, the single transfer SHALL move IDLE directly to LOADED.
REQ-010 start SHALL be ignored in every state except LOADED, including in the cycle of the DIM-th transfer.
REQ-011 start=1 in LOADED SHALL move to SHIFT. en SHALL be 1 for exactly 2*DIM-1 consecutive cycles, beginning the cycle after start is sampled.
REQ-012 The cycle after the last en=1 cycle SHALL be DONE with done=1 for exactly one cycle; the next cycle SHALL be IDLE.
REQ-013 WrEn and en SHALL never be 1 in the same cycle.
REQ-014 Row counter width SHALL be $clog2(DIM+1). Shift counter width SHALL be $clog2(2*DIM). Neither SHALL wrap within a matrix; both SHALL clear on entry to IDLE.
REQ-015 row_valid during LOADED, SHIFT or DONE SHALL cause no transfer and SHALL not alter any counter.

Reset
REQ-016 rst_n=0 SHALL immediately force the following, regardless of the current state, including mid-LOAD or mid-SHIFT:
- state IDLE; counters 0
- WrEn=0, en=0, done=0, busy=0
- Arow=0, Ain all zeros
REQ-017 row_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after reset release.

Structure
REQ-018 A shared package SHALL hold the state enum typedef and the shift-length function (2*DIM-1) so the B-side controller can reuse them.
REQ-019 The block SHALL be a single module with no sub-modules. The A buffer SHALL be instantiated by the parent, connected to WrEn/Arow/Ain/en.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs, except row_ready, which SHALL depend on state only.

Verification (DIM=8, BITS_AB=8)
REQ-021 Bench SHALL cover:
- Back-to-back load: row_valid=1 for 8 cycles, rows 0x01..0x08 -> WrEn high 8 cycles, Arow 0..7, Ain matches, then LOADED with row_ready=0.
- Gapped load: row_valid 1,0,1,0 pattern -> exactly 8 WrEn pulses with Arow incrementing only on transfers.
- Shift: start in LOADED -> en high exactly 15 cycles, done pulse on cycle 16, IDLE and row_ready=1 on cycle 17.
- Early start: start pulsed in IDLE and on the 8th transfer cycle -> no en. A later start in LOADED -> normal 15-cycle shift.
- Reset mid-SHIFT: rst_n low after 5 en cycles -> en=0 immediately, no done. A fresh 8-row load plus start afterwards completes normally.
- Blocked rows: row_valid=1 throughout SHIFT with data 0xFF -> no WrEn, Ain unchanged.
